// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-stage stream source.
// Holds the FSM state type and the reset content pattern.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mss_state_e;

  // Word i of the reset image; caller truncates to its word width.
  function automatic logic [63:0] init_word(
    input logic [63:0] base,
    input int unsigned i
  );
    return base | (64'(i + 1) << 16);
  endfunction

endpackage

// File: rtl/mss_tap_chain.sv
// Delayed-output shift register for the stream source.
// Tap k holds the word accepted k+1 transfers ago.
module mss_tap_chain #(
  parameter int DATA_W = 32,
  parameter int TAPS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic [DATA_W-1:0]      din,
  output logic [TAPS*DATA_W-1:0] taps_o
);

  logic [DATA_W-1:0] tap_q [TAPS];
  logic [DATA_W-1:0] tap_d [TAPS];

  always_comb begin
    tap_d = tap_q;
    if (shift_en) begin
      tap_d[0] = din;
      for (int k = 1; k < TAPS; k++) begin
        tap_d[k] = tap_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      tap_q <= tap_d;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_out
    assign taps_o[k*DATA_W +: DATA_W] = tap_q[k];
  end

endmodule

// File: rtl/mem_stage_stream.sv
// Run-time writable word store streamed over valid/ready,
// with stop/wrap end modes and delayed output taps.
module mem_stage_stream
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TAPS   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(32'h2400_0000),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode_wrap,
  input  logic [AW-1:0]          last_addr,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAPS*DATA_W-1:0] out_delayed,
  output logic [AW-1:0]          pc,
  output logic                   done
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  mss_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [AW-1:0]     eff_last;
  logic [AW-1:0]     pc_inc;
  logic              at_end;
  logic              xfer;

  assign eff_last = (int'(last_addr) >= DEPTH) ? AW'(DEPTH-1) : last_addr;
  assign pc_inc   = pc_q + AW'(1);
  // Last word of the store always ends the pass, even if last_addr moved below pc.
  assign at_end   = (pc_q == eff_last) || (int'(pc_q) == DEPTH-1);
  assign xfer     = (state_q == RUN) && valid_q && out_ready;

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Loads read mem_q, so a same-cycle write is seen only next time.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          data_d  = mem_q[0];
          pc_d    = '0;
          valid_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (!at_end) begin
            pc_d   = pc_inc;
            data_d = mem_q[pc_inc];
          end else if (mode_wrap) begin
            pc_d   = '0;
            data_d = mem_q[0];
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(init_word(64'(INIT_VAL), i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  mss_tap_chain #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_taps (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (xfer),
    .din      (data_q),
    .taps_o   (out_delayed)
  );

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign pc        = pc_q;
  assign done      = done_q;

endmodule

// File: doc/mem_stage_stream.md
# mem_stage_stream

Parametrised instruction/data stream source for pipeline bring-up. It replaces the fixed 10-entry mock memory stage with a configurable-width, configurable-depth word store. The store is writable at run time and streams words through a valid/ready handshake, with stop or wrap end-of-stream modes and a configurable chain of delayed output taps. It sits at the memory-stage position and feeds the downstream stage under test.

## Interface
- `DATA_W`, 32, word width.
- `DEPTH`, 16, number of words; `AW = $clog2(DEPTH)` (min 1).
- `TAPS`, 2, number of delayed output taps (≥1).
- `INIT_VAL`, 32'h2400_0000, reset/initial content base: word i = `INIT_VAL | (i+1) << 16` (truncated to `DATA_W`).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin stream at address 0; honoured in IDLE or DONE only.
- `mode_wrap` in 1: 0 = stop after `last_addr`; 1 = wrap to 0. Sampled every cycle.
- `last_addr` in AW: final address of the stream; values ≥ DEPTH treated as DEPTH-1.
- `wr_en` in 1, `wr_addr` in AW, `wr_data` in DATA_W: store write port; out-of-range `wr_addr` ignored.
- `out_ready` in 1: downstream accepts.
- `out_valid` out 1, `out_data` out DATA_W: current stream word.
- `out_delayed` out TAPS*DATA_W: tap k (bits `[k*DATA_W +: DATA_W]`) = word accepted k+1 transfers ago.
- `pc` out AW: address of the word currently in `out_data`.
- `done` out 1: stream finished (stop mode).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + `start`:
  - go RUN;
  - `out_data` ← mem[0];
  - `pc` ← 0;
  - `out_valid` ← 1;
  - `done` ← 0.
- RUN, transfer (`out_valid && out_ready`):
  - tap chain shifts (tap0 ← `out_data`, tap k ← tap k-1);
  - if `pc` ≠ eff_last: `pc` ← pc+1, `out_data` ← mem[pc+1].
  - if `pc` = eff_last and `mode_wrap`=1: `pc` ← 0, `out_data` ← mem[0].
  - if `pc` = eff_last and `mode_wrap`=0: go DONE, `out_valid` ← 0, `done` ← 1, `out_data`/`pc` hold.
- RUN, no transfer: `out_data`, `pc`, taps hold (stable under backpressure).
- `start` while RUN: ignored.
- Write port:
  - synchronous; mem[wr_addr] ← wr_data.
  - Same-cycle write to the address being loaded into `out_data`: old data is loaded (read-first).
- Reset:
  - the store reloads the `INIT_VAL` pattern;
  - all outputs clear, including mid-stream;
  - `out_valid`=0, `done`=0.
- Changing `last_addr` below the current `pc` in RUN: the stream continues to DEPTH-1, then applies the end rule at DEPTH-1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_delayed`=0, `pc`=0, `done`=0.
- Latency `start` → `out_valid`: 1 cycle (registered).
- Throughput: 1 word/cycle with `out_ready` held high.
- `done` rises the cycle after the final transfer, in the same edge as `out_valid` falls.
- Taps update only on transfers, never on idle cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mem_stage_pkg`:
  - state enum `mss_state_e` {IDLE, RUN, DONE};
  - the `INIT_VAL` pattern function `init_word(i)`.
- One sub-module, `mss_tap_chain`: parametrised `DATA_W`/`TAPS` shift register with shift enable and async active-low clear.
- Word store: `reg` array with async read and sync write, inside the top module.

## Test plan
- Reset, then `start` with `last_addr`=9, `mode_wrap`=0, `out_ready`=1 → words 0x24010000…0x240A0000 on consecutive cycles; `done`=1 one cycle after the 0x240A0000 transfer; `out_valid`=0.
- Same run with `mode_wrap`=1, `last_addr`=2 → sequence 0x24010000, 0x24020000, 0x24030000, 0x24010000…; `pc` 0,1,2,0.
- `out_ready` toggled 1,0,0,1 → `out_data`, `pc` and taps frozen during 0 cycles. After 3 transfers: tap0=word2, tap1=word1.
- `wr_en` to addr 5 with 0xDEADBEEF before `start` → 6th streamed word = 0xDEADBEEF. Write to the address being loaded in the same cycle → old word streamed.
- `rst_n` low mid-stream at `pc`=4 → all outputs 0 immediately (asynchronous), state IDLE, store restored to the init pattern.
- `start` pulsed in RUN → ignored. `last_addr`=31 with DEPTH=16 → stream stops after address 15.
